// File: rtl/gb_pkg.sv
// gb_pkg: constants and types shared by the OAM DMA controller files.
//   fsm_state_t : DMA sequencer states. A transfer runs START once, then loops
//                 RD/LAT/WR/GAP once per byte.
//   BYTES, SLOT : bytes per transfer and clocks per byte slot.
//   ADDR_DMA, OAM_BASE, HIGH_BASE : fixed addresses the controller decodes.
//   echo_map()  : folds echo-RAM source pages (0xE0-0xFF) onto 0xC0-0xDF.
package gb_pkg;

  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_START = 3'd1,
    FSM_RD    = 3'd2,
    FSM_LAT   = 3'd3,
    FSM_WR    = 3'd4,
    FSM_GAP   = 3'd5
  } fsm_state_t;

  localparam int BYTES = 160;
  localparam int SLOT  = 4;

  localparam logic [7:0]  LAST_IDX  = 8'(BYTES - 1);
  localparam logic [15:0] ADDR_DMA  = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] HIGH_BASE = 16'hFF00;

  // Source pages in echo RAM mirror work RAM 0x2000 lower.
  function automatic logic [7:0] echo_map(input logic [7:0] hi);
    return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: combinational CPU/DMA multiplexer for the system bus.
//   state          : current DMA sequencer state
//   A_cpu, Di_cpu, wr_cpu, rd_cpu : CPU request
//   dma_addr       : DMA source address for the current byte
//   dma_reg        : local 0xFF46 register value (read back to the CPU)
//   Di_bus         : MMU read data
//   Do_cpu, stall_cpu : response to the CPU
//   A_bus, Do_bus, wr_bus, rd_bus : request presented to the MMU
// While a transfer runs, only the 0xFF page stays reachable; the DMA read
// slot always wins and stalls a competing high-page CPU access.
module dma_bus_arbiter
  import gb_pkg::*;
(
  input  fsm_state_t  state,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_reg,
  input  logic [7:0]  Di_bus,
  output logic [7:0]  Do_cpu,
  output logic        stall_cpu,
  output logic [15:0] A_bus,
  output logic [7:0]  Do_bus,
  output logic        wr_bus,
  output logic        rd_bus
);

  logic is_dma_reg;
  logic is_high;
  logic dma_idle;
  logic dma_rd;

  assign is_dma_reg = (A_cpu == ADDR_DMA);
  assign is_high    = (A_cpu[15:8] == HIGH_BASE[15:8]);
  assign dma_idle   = (state == FSM_IDLE);
  assign dma_rd     = (state == FSM_RD);

  always_comb begin
    A_bus     = A_cpu;
    Do_bus    = Di_cpu;
    wr_bus    = 1'b0;
    rd_bus    = 1'b0;
    stall_cpu = 1'b0;
    Do_cpu    = 8'hFF;   // open-bus value for blocked reads

    if (is_dma_reg) begin
      // The DMA register is served locally and never reaches the MMU.
      Do_cpu = dma_reg;
    end else if (dma_idle) begin
      wr_bus = wr_cpu;
      rd_bus = rd_cpu;
      Do_cpu = Di_bus;
    end else if (is_high) begin
      if (dma_rd) begin
        stall_cpu = wr_cpu | rd_cpu;
      end else begin
        wr_bus = wr_cpu;
        rd_bus = rd_cpu;
        Do_cpu = Di_bus;
      end
    end

    // The DMA read owns the bus for its whole clock.
    if (dma_rd) begin
      A_bus  = dma_addr;
      rd_bus = 1'b1;
      wr_bus = 1'b0;
    end
  end

endmodule

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: OAM DMA sequencer triggered by a CPU write to 0xFF46.
// Copies 160 bytes from {src,00}..{src,9F} into OAM FE00..FE9F, one byte per
// 4-clock slot, while arbitrating the shared bus with the CPU.
//   clock, reset_n : clock and asynchronous active-low reset
//   A_cpu, Di_cpu, wr_cpu, rd_cpu, Do_cpu, stall_cpu : CPU side
//   A_bus, Do_bus, wr_bus, rd_bus, Di_bus : MMU side (read data one clock late)
//   A_oam, Do_oam, wr_oam : OAM write port, zero outside the write clock
//   dma_active : transfer in progress
module oam_dma_controller
  import gb_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic [7:0]  Do_cpu,
  output logic        stall_cpu,
  output logic [15:0] A_bus,
  output logic [7:0]  Do_bus,
  input  logic [7:0]  Di_bus,
  output logic        wr_bus,
  output logic        rd_bus,
  output logic [15:0] A_oam,
  output logic [7:0]  Do_oam,
  output logic        wr_oam,
  output logic        dma_active
);

  fsm_state_t state_reg;
  fsm_state_t state_next;
  logic [7:0] idx_reg;
  logic [7:0] src_reg;
  logic [7:0] data_q;
  logic [7:0] dma_reg;
  logic       wr_q;
  logic       trigger;

  // Only the first clock of a (possibly long) CPU write strobe starts a DMA.
  assign trigger = wr_cpu & (A_cpu == ADDR_DMA) & ~wr_q;

  // State register, byte counter, source page and data latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FSM_IDLE;
      idx_reg   <= 8'h00;
      src_reg   <= 8'h00;
      data_q    <= 8'h00;
      dma_reg   <= 8'h00;
      wr_q      <= 1'b0;
    end else begin
      state_reg <= state_next;
      wr_q      <= wr_cpu;
      if (trigger) begin
        dma_reg <= Di_cpu;
        src_reg <= echo_map(Di_cpu);
        idx_reg <= 8'h00;
      end else if (state_reg == FSM_GAP && idx_reg != LAST_IDX) begin
        idx_reg <= idx_reg + 8'd1;
      end
      if (state_reg == FSM_LAT) begin
        data_q <= Di_bus;
      end
    end
  end

  // Next state: a trigger restarts from any state, including the last GAP.
  always_comb begin
    state_next = state_reg;
    if (trigger) begin
      state_next = FSM_START;
    end else begin
      unique case (state_reg)
        FSM_IDLE:  state_next = FSM_IDLE;
        FSM_START: state_next = FSM_RD;
        FSM_RD:    state_next = FSM_LAT;
        FSM_LAT:   state_next = FSM_WR;
        FSM_WR:    state_next = FSM_GAP;
        FSM_GAP:   state_next = (idx_reg == LAST_IDX) ? FSM_IDLE : FSM_RD;
        default:   state_next = FSM_IDLE;
      endcase
    end
  end

  // OAM-side outputs.
  always_comb begin
    dma_active = (state_reg != FSM_IDLE);
    wr_oam     = 1'b0;
    A_oam      = 16'h0000;
    Do_oam     = 8'h00;
    if (state_reg == FSM_WR) begin
      wr_oam = 1'b1;
      A_oam  = OAM_BASE | {8'h00, idx_reg};
      Do_oam = data_q;
    end
  end

  dma_bus_arbiter u_arbiter (
    .state     (state_reg),
    .A_cpu     (A_cpu),
    .Di_cpu    (Di_cpu),
    .wr_cpu    (wr_cpu),
    .rd_cpu    (rd_cpu),
    .dma_addr  ({src_reg, idx_reg}),
    .dma_reg   (dma_reg),
    .Di_bus    (Di_bus),
    .Do_cpu    (Do_cpu),
    .stall_cpu (stall_cpu),
    .A_bus     (A_bus),
    .Do_bus    (Do_bus),
    .wr_bus    (wr_bus),
    .rd_bus    (rd_bus)
  );

endmodule

// File: doc/oam_dma_controller.md
# oam_dma_controller

Sequences the OAM DMA transfer triggered by a CPU write to 0xFF46. It copies 160 bytes from `{src,8'h00}`..`{src,8'h9F}` into OAM 0xFE00..0xFE9F. It sits between the CPU and the system MMU bus and owns the OAM write port while active. While a transfer runs, it arbitrates the shared bus between DMA reads and CPU accesses, so the CPU can only reach 0xFF00-0xFFFF.

## Interface
- `BYTES`, 160: bytes per transfer.
- `SLOT`, 4: clocks per byte slot (one M-cycle).

Ports:
- `clock`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `A_cpu`  in  16  CPU address
- `Di_cpu`  in  8  CPU write data
- `wr_cpu` / `rd_cpu`  in  1  CPU strobes (level, may span several clocks)
- `Do_cpu`  out  8  read data to CPU (combinational)
- `stall_cpu`  out  1  CPU must hold its request this clock
- `A_bus`  out  16  address to MMU
- `Do_bus`  out  8  write data to MMU
- `Di_bus`  in  8  MMU read data, valid one clock after `rd_bus`
- `wr_bus` / `rd_bus`  out  1  MMU strobes
- `A_oam`  out  16  OAM write address
- `Do_oam`  out  8  OAM write data
- `wr_oam`  out  1  OAM write strobe
- `dma_active`  out  1  transfer in progress; the PPU treats OAM as busy

## Operation
- Register `dma_reg` (8b) resets to 0x00. CPU reads of 0xFF46 return `dma_reg` locally and are not forwarded. Writes are not forwarded either.
- Trigger condition: `wr_cpu & A_cpu==16'hFF46 & ~wr_q`, where `wr_q` is `wr_cpu` registered. Only the first clock of a held write triggers.
- On trigger:
  - `dma_reg` <= `Di_cpu`.
  - Source high byte `src` = `Di_cpu`; values 0xE0-0xFF map to `Di_cpu-8'h20` (echo RAM).
  - `idx` <= 0, state <= START.
  - A trigger while active restarts the transfer from `idx`=0 with the new source. The byte in flight is abandoned with no OAM write.
- FSM:
  - IDLE: wait for trigger.
  - START: 1 clock.
  - RD: drive `A_bus={src,idx}`, `rd_bus`=1.
  - LAT: latch `Di_bus` into `data_q`.
  - WR: drive `A_oam=16'hFE00+idx`, `Do_oam=data_q`, `wr_oam`=1.
  - GAP: if `idx==BYTES-1`, go to IDLE; else `idx++` and go to RD.
- `idx` is 8 bits and never exceeds 159.
- `dma_active`=1 in every state except IDLE.
- CPU path when IDLE: transparent. `A_bus`, `Do_bus`, `wr_bus`, `rd_bus` follow the CPU; `Do_cpu=Di_bus`; `stall_cpu`=0. The 0xFF46 exception above still applies.
- CPU path when active:
  - Access to 0xFF00-0xFFFF (excluding 0xFF46) passes through in START, LAT, WR, GAP.
  - The same access in RD asserts `stall_cpu` and is not forwarded. The DMA wins.
  - Any other address: reads return 0xFF, writes are dropped, and nothing is forwarded. `stall_cpu`=0.
- Reset mid-transfer returns to IDLE immediately. No OAM write follows.

## Timing
- Reset values: `dma_active`=0, `wr_oam`=0, `A_oam`=0, `Do_oam`=0, `stall_cpu`=0. The bus outputs mirror the CPU (IDLE).
- Trigger edge T: START at T+1, first RD at T+2, first `wr_oam` at T+4. Byte n is written at T+4+4n. The last write (byte 159) is at T+640.
- `dma_active` rises at T+1 and falls at T+642, the first IDLE clock. The CPU regains full access that clock.
- The OAM write always follows its bus read by exactly 2 clocks.
- Restart on the last GAP clock: the restart takes priority over the transition to IDLE.

## Structure
- Shared package `gb_pkg`:
  - `FSM_IDLE..FSM_GAP` encoding.
  - `ADDR_DMA=16'hFF46`, `OAM_BASE=16'hFE00`, `HIGH_BASE=16'hFF00`.
- One natural sub-module: `dma_bus_arbiter`. It is the combinational CPU/DMA mux and stall logic, taking state and addresses as inputs. The FSM, counters and `dma_reg` stay in the top.

## Test plan
- Pulse write 0x12 to 0xFF46 with the bus model returning `A_bus[7:0]^8'h5A`. Expect:
  - 160 `wr_oam` pulses at FE00..FE9F with matching data.
  - The first at T+4, the last at T+640.
  - `dma_active` falling at T+642.
- Write 0xE3 to 0xFF46. Expect `A_bus` reads 0xC300..0xC39F. A CPU read of 0xFF46 returns 0xE3.
- During DMA, the CPU reads 0xC000 and writes 0x8000. Expect `Do_cpu`=0xFF, no `wr_bus` from the CPU, `stall_cpu`=0.
- During DMA, the CPU reads 0xFF80 held across a full slot. Expect `stall_cpu` only in RD clocks; the read completes in the next non-RD clock.
- At `idx`=50, write 0x20 to 0xFF46. Expect no write to FE32 from the old source, a new sequence starting at FE00 from 0x2000, and `dma_active` staying high.
- Assert `reset_n` low at `idx`=80 for one clock. Expect `dma_active`=0 and `wr_oam`=0 at once, `dma_reg`=0x00, and no further OAM writes.
